// File: rtl/opti_coeffs_bank.sv
// Double-buffered biquad coefficient store.
// The loader edits the shadow bank. A commit swaps the banks at the next frame_start, then the
// new active bank is copied back into the shadow bank so that later edits stay incremental.
module opti_coeffs_bank #(
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned FRAC_BITS = 14,
    parameter int unsigned N_STAGES  = 6,
    parameter int unsigned IDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    // Loader port (writes the shadow bank)
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  load_stage,
    input  logic [2:0]        load_sel,
    input  logic [COEF_W-1:0] load_data,
    output logic              load_err,
    // Bank swap control
    input  logic              commit,
    input  logic              frame_start,
    output logic              swap_pending,
    output logic              bank_sel,
    // Read port (reads the active bank)
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  stage_index,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic              rd_valid
);

    localparam int unsigned       IdxW1     = IDX_W + 1;
    localparam logic [IDX_W:0]    NStages   = IdxW1'(N_STAGES);
    localparam logic [IDX_W-1:0]  LastStage = IDX_W'(N_STAGES - 1);
    localparam logic [COEF_W-1:0] Unity     = COEF_W'(1) << FRAC_BITS;

    typedef enum logic [1:0] {StIdle, StPending, StCopy} state_e;

    state_e            state_q, state_d;
    logic              bank_sel_q, bank_sel_d;
    logic [IDX_W-1:0]  copy_stage_q, copy_stage_d;
    logic [2:0]        copy_sel_q, copy_sel_d;
    logic              load_err_q;

    // Coefficient storage: [bank][stage][b0,b1,b2,a1,a2]
    logic [COEF_W-1:0] mem_q [2][N_STAGES][5];

    // Single write port shared by the loader (IDLE) and the copy engine (COPY)
    logic              wr_en;
    logic              wr_bank;
    logic [IDX_W-1:0]  wr_stage;
    logic [2:0]        wr_sel;
    logic [COEF_W-1:0] wr_data;

    logic              load_acc;
    logic              load_addr_ok;

    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_stage;
    logic [COEF_W-1:0] rd_b0, rd_b1, rd_b2, rd_a1, rd_a2;
    logic [COEF_W-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic              rd_valid_q;

    // Loader handshake and address check
    always_comb begin
        load_ready   = (state_q == StIdle);
        swap_pending = (state_q == StPending);
        load_acc     = load_valid && load_ready;
        load_addr_ok = ({1'b0, load_stage} < NStages) && (load_sel < 3'd5);
    end

    // FSM next state, bank toggle, copy walker and write-port steering
    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        copy_stage_d = copy_stage_q;
        copy_sel_d   = copy_sel_q;
        wr_en        = 1'b0;
        wr_bank      = ~bank_sel_q;
        wr_stage     = load_stage;
        wr_sel       = load_sel;
        wr_data      = load_data;
        unique case (state_q)
            StIdle: begin
                // A write in the commit cycle still lands before the swap is armed
                wr_en = load_acc && load_addr_ok;
                if (commit) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (frame_start) begin
                    bank_sel_d   = ~bank_sel_q;
                    copy_stage_d = '0;
                    copy_sel_d   = '0;
                    state_d      = StCopy;
                end
            end
            StCopy: begin
                wr_en    = 1'b1;
                wr_stage = copy_stage_q;
                wr_sel   = copy_sel_q;
                wr_data  = mem_q[bank_sel_q][copy_stage_q][copy_sel_q];
                if (copy_sel_q == 3'd4) begin
                    copy_sel_d = '0;
                    if (copy_stage_q == LastStage) begin
                        state_d = StIdle;
                    end else begin
                        copy_stage_d = copy_stage_q + 1'b1;
                    end
                end else begin
                    copy_sel_d = copy_sel_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bank_sel_q   <= 1'b0;
            copy_stage_q <= '0;
            copy_sel_q   <= '0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            copy_stage_q <= copy_stage_d;
            copy_sel_q   <= copy_sel_d;
            load_err_q   <= load_acc && !load_addr_ok;
        end
    end

    // Coefficient storage: reset to passthrough, one write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < int'(N_STAGES); s++) begin
                    mem_q[b][s][0] <= Unity;
                    for (int k = 1; k < 5; k++) begin
                        mem_q[b][s][k] <= '0;
                    end
                end
            end
        end else if (wr_en) begin
            mem_q[wr_bank][wr_stage][wr_sel] <= wr_data;
        end
    end

    // Read mux; out-of-range stages see the passthrough set
    always_comb begin
        rd_in_range = ({1'b0, stage_index} < NStages);
        rd_stage    = rd_in_range ? stage_index : '0;
        rd_b0       = Unity;
        rd_b1       = '0;
        rd_b2       = '0;
        rd_a1       = '0;
        rd_a2       = '0;
        if (rd_in_range) begin
            rd_b0 = mem_q[bank_sel_q][rd_stage][0];
            rd_b1 = mem_q[bank_sel_q][rd_stage][1];
            rd_b2 = mem_q[bank_sel_q][rd_stage][2];
            rd_a1 = mem_q[bank_sel_q][rd_stage][3];
            rd_a2 = mem_q[bank_sel_q][rd_stage][4];
        end
    end

    // Registered read outputs; they hold while rd_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                b0_q <= rd_b0;
                b1_q <= rd_b1;
                b2_q <= rd_b2;
                a1_q <= rd_a1;
                a2_q <= rd_a2;
            end
        end
    end

    // Output assignments
    always_comb begin
        bank_sel = bank_sel_q;
        load_err = load_err_q;
        b0       = b0_q;
        b1       = b1_q;
        b2       = b2_q;
        a1       = a1_q;
        a2       = a2_q;
        rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_opti_coeffs_bank.sv
// Directed bench for opti_coeffs_bank: reset state, loading, commit/swap timing,
// copy-back length, invalid-address handling and reset during the copy.
module tb_opti_coeffs_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_stage;
    logic [2:0]  load_sel;
    logic [15:0] load_data;
    logic        load_err;
    logic        commit;
    logic        frame_start;
    logic        swap_pending;
    logic        bank_sel;
    logic        rd_en;
    logic [2:0]  stage_index;
    logic [15:0] b0, b1, b2, a1, a2;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;
    int low;

    opti_coeffs_bank #(
        .COEF_W   (16),
        .FRAC_BITS(14),
        .N_STAGES (6),
        .IDX_W    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_stage  (load_stage),
        .load_sel    (load_sel),
        .load_data   (load_data),
        .load_err    (load_err),
        .commit      (commit),
        .frame_start (frame_start),
        .swap_pending(swap_pending),
        .bank_sel    (bank_sel),
        .rd_en       (rd_en),
        .stage_index (stage_index),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .a1          (a1),
        .a2          (a2),
        .rd_valid    (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] st, input logic [2:0] sel, input logic [15:0] d);
        load_valid = 1'b1;
        load_stage = st;
        load_sel   = sel;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] st, input logic [15:0] e0,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e4);
        rd_en       = 1'b1;
        stage_index = st;
        tick();
        rd_en = 1'b0;
        check({tag, "_b0"}, 64'(b0), 64'(e0));
        check({tag, "_rest"}, {b1, b2, a1, a2}, {e1, e2, e3, e4});
        check({tag, "_vld"}, 64'(rd_valid), 64'd1);
    endtask

    // commit then frame_start; leaves the FSM in COPY
    task automatic swap();
        commit = 1'b1;
        tick();
        commit      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!load_ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(load_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_stage = '0; load_sel = '0; load_data = '0;
        commit = 1'b0; frame_start = 1'b0; rd_en = 1'b0; stage_index = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and passthrough reads including an out-of-range stage
        check("rst_ready", 64'(load_ready), 64'd1);
        check("rst_bank", 64'(bank_sel), 64'd0);
        check("rst_pend", 64'(swap_pending), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_out", {b0, b1, b2, a1, a2, rd_valid}, 64'd0);
        for (int s = 0; s < 6; s++) read_check($sformatf("pt%0d", s), 3'(s), 16'h4000, 0, 0, 0, 0);
        read_check("pt7", 3'd7, 16'h4000, 0, 0, 0, 0);
        tick();
        check("idle_vld", 64'(rd_valid), 64'd0);
        check("idle_hold", 64'(b0), 64'h4000);

        // 2: load stage0 b1, commit, hold off frame_start
        load(3'd0, 3'd1, 16'hDBDB);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_en = 1'b1; stage_index = 3'd0;
            tick();
        end
        rd_en = 1'b0;
        check("pend_b1", 64'(b1), 64'd0);
        check("pend_flag", 64'(swap_pending), 64'd1);
        check("pend_ready", 64'(load_ready), 64'd0);
        check("pend_bank", 64'(bank_sel), 64'd0);

        // 4: read in the swap cycle sees the old bank, the next cycle the new one
        frame_start = 1'b1; rd_en = 1'b1; stage_index = 3'd0;
        tick();
        frame_start = 1'b0;
        check("swap_old_b1", 64'(b1), 64'd0);
        check("swap_bank", 64'(bank_sel), 64'd1);
        check("swap_pend", 64'(swap_pending), 64'd0);
        check("copy_ready0", 64'(load_ready), 64'd0);
        low = 1;
        tick();
        rd_en = 1'b0;
        check("swap_new_b1", 64'(b1), 64'hDBDB);
        check("swap_new_b0", 64'(b0), 64'h4000);

        // 3: copy keeps load_ready low for exactly 30 cycles, then shadow matches active
        while (!load_ready && low < 100) begin
            low++;
            tick();
        end
        check("copy_len", 64'(low), 64'd30);
        swap();
        check("swap2_bank", 64'(bank_sel), 64'd0);
        read_check("copyback", 3'd0, 16'h4000, 16'hDBDB, 0, 0, 0);
        wait_idle("idle_to2");

        // 5: invalid addresses pulse load_err and write nothing
        load(3'd6, 3'd0, 16'h1234);
        check("err_stage", 64'(load_err), 64'd1);
        tick();
        check("err_pulse", 64'(load_err), 64'd0);
        load(3'd0, 3'd5, 16'h5678);
        check("err_sel", 64'(load_err), 64'd1);
        load(3'd2, 3'd4, 16'h8001);
        check("ok_noerr", 64'(load_err), 64'd0);
        swap();
        check("swap3_bank", 64'(bank_sel), 64'd1);
        read_check("after_err0", 3'd0, 16'h4000, 16'hDBDB, 0, 0, 0);
        read_check("after_err2", 3'd2, 16'h4000, 0, 0, 0, 16'h8001);
        read_check("after_err7", 3'd7, 16'h4000, 0, 0, 0, 0);
        wait_idle("idle_to3");

        // 6: reset in the middle of a copy
        load(3'd5, 3'd3, 16'hF00F);
        swap();
        tick(); tick(); tick();
        check("mid_copy", 64'(load_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rc_ready", 64'(load_ready), 64'd1);
        check("rc_bank", 64'(bank_sel), 64'd0);
        check("rc_pend", 64'(swap_pending), 64'd0);
        check("rc_out", {b0, b1, b2, a1, a2, rd_valid}, 64'd0);
        read_check("rc_s0", 3'd0, 16'h4000, 0, 0, 0, 0);
        read_check("rc_s2", 3'd2, 16'h4000, 0, 0, 0, 0);
        read_check("rc_s5", 3'd5, 16'h4000, 0, 0, 0, 0);
        swap();
        check("rc_swap_bank", 64'(bank_sel), 64'd1);
        read_check("rc_sh0", 3'd0, 16'h4000, 0, 0, 0, 0);
        read_check("rc_sh5", 3'd5, 16'h4000, 0, 0, 0, 0);
        wait_idle("idle_to4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
